// File: rtl/keypad_priority_encoder.sv
// 10-key keypad encoder: 2-flop synchroniser, highest-index priority encode, debounce,
// active-low enable. D holds the accepted BCD digit (4'hF when idle/disabled).
module keypad_priority_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keypad,
  input  logic       enablen,
  output logic [3:0] D,
  output logic       valid,
  output logic       key_pulse
);

  localparam logic [3:0] NoKey  = 4'hF;
  localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES);

  logic [9:0] sync1_q, sync2_q;
  logic       enablen_q;
  logic [3:0] raw_code;
  logic [3:0] cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       pulse_q, pulse_d;

  // Ascending scan: the last set bit seen (highest index) wins.
  always_comb begin
    raw_code = NoKey;
    for (int i = 0; i < 10; i++) begin
      if (sync2_q[i]) raw_code = 4'(i);
    end
  end

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = valid_q;
    pulse_d = 1'b0;

    if (raw_code != cand_q) begin
      cand_d = raw_code;
      cnt_d  = 8'd1;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 8'd1;
    end

    if ((cnt_d == CntMax) && (cand_d != code_q)) begin
      code_d  = cand_d;
      valid_d = (cand_d != NoKey);
      pulse_d = (cand_d != NoKey);
    end

    // Disable acts on the sampling edge; counting only resumes once enablen was low
    // on the previous edge too, so a held key needs a full debounce after re-enable.
    if (enablen || enablen_q) begin
      code_d  = NoKey;
      valid_d = 1'b0;
      pulse_d = 1'b0;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      enablen_q <= 1'b0;
      cand_q    <= NoKey;
      cnt_q     <= 8'd0;
      code_q    <= NoKey;
      valid_q   <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      sync1_q   <= keypad;
      sync2_q   <= sync1_q;
      enablen_q <= enablen;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      pulse_q   <= pulse_d;
    end
  end

  assign D         = code_q;
  assign valid     = valid_q;
  assign key_pulse = pulse_q;

endmodule

// File: tb/tb_keypad_priority_encoder.sv
// Self-checking bench for keypad_priority_encoder: per-edge scoreboard fed by a
// stable-window reference model, plus directed latency and pulse-count checks.
module tb_keypad_priority_encoder;

  localparam int unsigned N = 4;
  localparam int HistLen = 2048;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] keypad;
  logic       enablen;
  logic [3:0] D;
  logic       valid;
  logic       key_pulse;

  keypad_priority_encoder #(.DEBOUNCE_CYCLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .keypad    (keypad),
    .enablen   (enablen),
    .D         (D),
    .valid     (valid),
    .key_pulse (key_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] d;
    logic       v;
    logic       p;
  } exp_t;

  exp_t       sb_q[$];
  logic [9:0] kp_hist [HistLen];
  logic       en_hist [HistLen];
  int         k;
  int         n_checks;
  int         n_pass;
  int         pulses;
  int         chg_k;
  logic [3:0] exp_d;
  logic [3:0] last_d;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
  endtask

  function automatic logic [3:0] enc(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) begin
      if (v[i]) return 4'(i);
    end
    return 4'hF;
  endfunction

  // Code the encoder sees at edge j: keypad value present two edges earlier.
  function automatic logic [3:0] raw_at(input int j);
    if (j < 3) return 4'hF;
    return enc(kp_hist[j-2]);
  endfunction

  function automatic bit active(input int j);
    if (j < 1) return 1'b0;
    if (en_hist[j]) return 1'b0;
    if (j > 1 && en_hist[j-1]) return 1'b0;
    return 1'b1;
  endfunction

  // Accepted at edge j when the last N edges were all enabled with one unchanged code.
  function automatic bit stable(input int j);
    for (int m = j - int'(N) + 1; m <= j; m++) begin
      if (!active(m) || raw_at(m) != raw_at(j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input logic [9:0] kp, input logic en);
    exp_t e;
    exp_t o;
    @(negedge clk);
    keypad  = kp;
    enablen = en;
    k++;
    if (k >= HistLen) begin
      $display("FAIL history: edge %0d exceeds %0d", k, HistLen);
      $fatal(1);
    end
    kp_hist[k] = kp;
    en_hist[k] = en;
    e.p = 1'b0;
    if (!active(k)) begin
      exp_d = 4'hF;
    end else if (stable(k) && raw_at(k) != exp_d) begin
      exp_d = raw_at(k);
      e.p   = (exp_d != 4'hF);
    end
    e.d = exp_d;
    e.v = (exp_d != 4'hF);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check_val("D", 32'(D), 32'(o.d));
    check_val("valid", 32'(valid), 32'(o.v));
    check_val("key_pulse", 32'(key_pulse), 32'(o.p));
    if (key_pulse === 1'b1) pulses++;
    if (D !== last_d) chg_k = k;
    last_d = D;
  endtask

  task automatic hold(input logic [9:0] kp, input logic en, input int n);
    repeat (n) step(kp, en);
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] one;
    int k0;
    int p0;
    one      = 10'd1;
    n_checks = 0;
    n_pass   = 0;
    pulses   = 0;
    chg_k    = 0;
    k        = 0;
    exp_d    = 4'hF;
    last_d   = 4'hF;
    rst      = 1'b1;
    keypad   = 10'b0000100000;
    enablen  = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("rst_D", 32'(D), 32'hF);
      check_val("rst_valid", 32'(valid), 32'd0);
      check_val("rst_pulse", 32'(key_pulse), 32'd0);
    end
    keypad = '0;
    rst    = 1'b0;
    hold(10'd0, 1'b0, 4);

    for (int i = 0; i < 10; i++) begin
      p0 = pulses;
      k0 = k + 1;
      hold(one << i, 1'b0, 10);
      check_val("sweep_D", 32'(D), 32'(i));
      check_val("sweep_latency", 32'(chg_k - k0), 32'd5);
      check_val("sweep_pulses", 32'(pulses - p0), 32'd1);
    end

    hold(10'b0100100100, 1'b0, 10);
    check_val("prio_8", 32'(D), 32'd8);
    hold(10'b1111111111, 1'b0, 10);
    check_val("prio_9", 32'(D), 32'd9);

    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      hold(one << i, 1'b1, 10);
      check_val("dis_D", 32'(D), 32'hF);
    end
    check_val("dis_pulses", 32'(pulses - p0), 32'd0);

    hold(10'd0, 1'b0, 10);
    p0 = pulses;
    hold(10'b0000100000, 1'b0, 3);
    hold(10'd0, 1'b0, 10);
    check_val("glitch_D", 32'(D), 32'hF);
    check_val("glitch_pulses", 32'(pulses - p0), 32'd0);

    p0 = pulses;
    hold(10'b0000100000, 1'b0, 4);
    step(10'd0, 1'b0);
    check_val("db_early", 32'(D), 32'hF);
    step(10'd0, 1'b0);
    check_val("db_accept", 32'(D), 32'd5);
    hold(10'd0, 1'b0, 3);
    check_val("rel_early", 32'(D), 32'd5);
    step(10'd0, 1'b0);
    check_val("rel_done", 32'(D), 32'hF);
    check_val("db_pulses", 32'(pulses - p0), 32'd1);

    hold(10'b0000000100, 1'b1, 8);
    p0 = pulses;
    k0 = k + 1;
    hold(10'b0000000100, 1'b0, 8);
    check_val("reen_D", 32'(D), 32'd2);
    check_val("reen_latency", 32'(chg_k - k0), 32'd4);
    check_val("reen_pulses", 32'(pulses - p0), 32'd1);

    hold(10'b0000001000, 1'b0, 10);
    p0 = pulses;
    k0 = k + 1;
    hold(10'b0010000000, 1'b0, 10);
    check_val("direct_D", 32'(D), 32'd7);
    check_val("direct_latency", 32'(chg_k - k0), 32'd5);
    check_val("direct_pulses", 32'(pulses - p0), 32'd1);

    // Reset asserted between edges mid-debounce must clear outputs at once.
    hold(10'b0000010000, 1'b0, 3);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_D", 32'(D), 32'hF);
    check_val("async_rst_valid", 32'(valid), 32'd0);
    check_val("async_rst_pulse", 32'(key_pulse), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_priority_encoder.md
Name: keypad_priority_encoder

Overview:
- Clocked 10-key keypad priority encoder with input synchronisation, debounce and an active-low enable.
- Converts one-hot or multi-hot key lines (digits 0..9) into a 4-bit BCD code plus valid and new-key strobe.
- Sits between the raw keypad inputs and the timer-entry/control logic.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive clock edges the encoded code must remain unchanged before it is accepted (legal range 1..255).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- keypad  input  10  raw key lines; bit i high = digit i pressed; asynchronous to clk.
- enablen  input  1  active-low enable; 0 = encoder active, 1 = disabled.
- D  output  4  accepted BCD code 0..9; 4'hF = no key / disabled.
- valid  output  1  high while D holds an accepted digit 0..9.
- key_pulse  output  1  one-cycle strobe when D takes a new digit.

Behaviour:
- Reset (async, rst=1): D=4'hF, valid=0, key_pulse=0; synchroniser, candidate and counter cleared. Outputs remain held until the first rising edge after rst falls.
- Synchroniser: keypad passes through a 2-flop synchroniser. The encoder sees the second stage only.
- Priority: highest index wins. If multiple bits are set, code = index of the highest set bit; e.g. 10'b1000000001 -> 9. All zero -> raw code 4'hF.
- enablen is sampled synchronously (no synchroniser) on each edge.
  - enablen=1 at an edge: D<=4'hF, valid<=0, key_pulse<=0, debounce counter cleared.
  - On return to enablen=0, debounce restarts from zero. A key already held is re-accepted after the full debounce time and raises key_pulse.
- Debounce: the candidate register tracks the raw code.
  - On each edge where raw equals the candidate, the counter increments (saturating at DEBOUNCE_CYCLES).
  - On a differing raw code, candidate<=raw and counter<=1.
  - When the counter reaches DEBOUNCE_CYCLES and the candidate differs from D: D<=candidate on that edge.
- Latency: D changes DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new keypad value. With the default of 4, that is the 6th edge.
- Glitch filtering: a keypad change shorter than DEBOUNCE_CYCLES clocks (after synchronisation) never reaches D.
- valid is registered together with D: valid = (D != 4'hF).
- key_pulse:
  - High for exactly one cycle on the edge D is loaded with a digit 0..9 different from its previous value (including from 4'hF).
  - Low when D goes to 4'hF.
  - No repeat while a key is held.
- Release is debounced like a press: D returns to 4'hF DEBOUNCE_CYCLES+2 edges after the keypad goes all-zero.
- Direct change between two keys (e.g. 3 -> 7 with no gap): D goes 3 -> 7 directly and key_pulse fires once.
- Simultaneous enablen=1 and a debounce completion on the same edge: disable wins.
- Reset mid-debounce: all state is discarded immediately.

Test Plan:
- Reset: rst=1 with keypad=10'b0000100000 -> D=4'hF, valid=0, key_pulse=0; stays so while rst=1.
- Sweep with enablen=0: apply 10'b0000000001, 10'b0000000010, ..., 10'b1000000000, each held 10 clocks. Expect D = 0,1,...,9, each appearing on the 6th edge after the change, with one key_pulse per step.
- Priority: keypad=10'b0100100100 -> D=8. Then 10'b1111111111 -> D=9.
- Disable: the same one-hot sweep with enablen=1 -> D=4'hF, valid=0, key_pulse never asserted.
- Debounce: a 3-clock pulse on bit 5 -> D stays 4'hF. A 4-clock hold on bit 5 -> D=5, key_pulse once. Release -> D=4'hF after 6 edges.
- Re-enable with key held: bit 2 held, enablen 1 -> 0 -> D=2 on the 5th edge after enablen falls, key_pulse=1 for one cycle.
